// File: rtl/calculator_pkg.sv
// Shared constants and state encoding for the calculator datapath.
package calculator_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_WORD_SIZE = 2 * DATA_W;
  localparam int unsigned ADDR_W        = 10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    ADD,
    PAD,
    WRITE,
    DONE
  } controller_state_t;

endpackage

// File: rtl/calc_controller.sv
// Sequencing controller: fetches operand words from SRAM, feeds the adder,
// steers sums into the result-buffer halves and commits buffer words to SRAM.
module calc_controller
  import calculator_pkg::*;
#(
  parameter int unsigned ADDR_W        = calculator_pkg::ADDR_W,
  parameter int unsigned DATA_W        = calculator_pkg::DATA_W,
  parameter int unsigned MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic                     mem_rd_en_o,
  output logic                     mem_wr_en_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  output logic                     loc_sel_o,
  output logic                     done_o
);

  controller_state_t state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] end_ptr;

  // FSM with registered outputs: each transition also sets the outputs the
  // next state presents, so strobes and addresses are glitch-free.
  // Operands and loc_sel are left untouched from ADD through WRITE because
  // the result buffer rewrites the selected half every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      end_ptr     <= '0;
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_addr_o  <= '0;
      op_a_o      <= '0;
      op_b_o      <= '0;
      loc_sel_o   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rd_ptr    <= read_start_addr_i;
            wr_ptr    <= write_start_addr_i;
            end_ptr   <= read_end_addr_i;
            loc_sel_o <= 1'b0;
            if (read_end_addr_i < read_start_addr_i) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state       <= READ;
              mem_rd_en_o <= 1'b1;
              mem_addr_o  <= read_start_addr_i;
            end
          end
        end
        READ: begin
          mem_rd_en_o <= 1'b0;
          mem_addr_o  <= '0;
          state       <= LATCH;
        end
        LATCH: begin
          op_a_o <= mem_rdata_i[DATA_W-1:0];
          op_b_o <= mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
          state  <= ADD;
        end
        ADD: begin
          if (loc_sel_o) begin
            state       <= WRITE;
            mem_wr_en_o <= 1'b1;
            mem_addr_o  <= wr_ptr;
          end else if (rd_ptr != end_ptr) begin
            state       <= READ;
            loc_sel_o   <= 1'b1;
            rd_ptr      <= rd_ptr + 1'b1;
            mem_rd_en_o <= 1'b1;
            mem_addr_o  <= rd_ptr + 1'b1;
          end else begin
            // Odd word count: force the upper half to 0 + 0.
            state     <= PAD;
            op_a_o    <= '0;
            op_b_o    <= '0;
            loc_sel_o <= 1'b1;
          end
        end
        PAD: begin
          state       <= WRITE;
          mem_wr_en_o <= 1'b1;
          mem_addr_o  <= wr_ptr;
        end
        WRITE: begin
          mem_wr_en_o <= 1'b0;
          wr_ptr      <= wr_ptr + 1'b1;
          loc_sel_o   <= 1'b0;
          if (rd_ptr == end_ptr) begin
            state      <= DONE;
            done_o     <= 1'b1;
            mem_addr_o <= '0;
          end else begin
            state       <= READ;
            rd_ptr      <= rd_ptr + 1'b1;
            mem_rd_en_o <= 1'b1;
            mem_addr_o  <= rd_ptr + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
